// File: rtl/inert_intf_if.sv
// rtl/inert_intf_if.sv - gyro SPI pins, interrupt and yaw-rate stream bundle
//
// Purpose: groups the signals that cross the inert_intf boundary so the
// design and its environment share one connection point.
//
// Signals:
//   INT     gyro data-ready interrupt (asynchronous, active high)
//   MISO    SPI data from gyro
//   SS_n    SPI select, active low
//   SCLK    SPI clock, idles high (mode 3)
//   MOSI    SPI data to gyro, MSB first
//   vld     one-cycle strobe, yaw_rt has just been updated
//   yaw_rt  signed yaw rate {yawH, yawL}
//
// Modports:
//   master  the inert_intf side (drives SPI outputs and the yaw stream)
//   slave   the gyro / integrator side
interface inert_intf_if;
    logic        INT;
    logic        MISO;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        vld;
    logic [15:0] yaw_rt;

    modport master (
        input  INT,
        input  MISO,
        output SS_n,
        output SCLK,
        output MOSI,
        output vld,
        output yaw_rt
    );

    modport slave (
        output INT,
        output MISO,
        input  SS_n,
        input  SCLK,
        input  MOSI,
        input  vld,
        input  yaw_rt
    );
endinterface

// File: rtl/inert_intf.sv
// rtl/inert_intf.sv - gyro configuration and yaw-rate reader over a mode-3 SPI master
//
// Purpose: after power-up waits 2^PWRUP_BITS clocks, writes three gyro
// configuration registers, then on every data-ready interrupt reads the
// yaw rate low and high bytes and publishes {yawH, yawL} with a one-cycle
// vld strobe.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    inert_intf_if.master: INT, MISO in; SS_n, SCLK, MOSI, vld, yaw_rt out
//
// Parameters:
//   PWRUP_BITS     width of the power-up wait timer
//   SCLK_DIV_BITS  SCLK period is 2^SCLK_DIV_BITS clocks (minimum 3)
module inert_intf #(
    parameter int PWRUP_BITS    = 16,
    parameter int SCLK_DIV_BITS = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    inert_intf_if.master  bus
);

    localparam int DW = SCLK_DIV_BITS;

    // Divider landmarks: SCLK is the divider MSB. Loading 10..1 gives a
    // short high front porch before the first falling edge; sampling at
    // 01..1 lands one clock before SCLK rises; all-ones is the clock
    // before SCLK falls, where the shift register advances.
    localparam logic [DW-1:0] DIV_PRESET = {2'b10, {(DW-2){1'b1}}};
    localparam logic [DW-1:0] DIV_SMPL   = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] DIV_ONES   = {DW{1'b1}};

    localparam logic [15:0] CMD_INT_CFG = 16'h0D02;  // INT on data ready
    localparam logic [15:0] CMD_ODR     = 16'h1160;  // gyro ODR 416 Hz
    localparam logic [15:0] CMD_ROUND   = 16'h1440;  // rounding enable
    localparam logic [15:0] CMD_RD_L    = 16'hA600;  // read yaw low byte
    localparam logic [15:0] CMD_RD_H    = 16'hA700;  // read yaw high byte

    // ------------------------------------------------------------------
    // SPI master
    // ------------------------------------------------------------------
    logic [DW-1:0] div_q, div_d;
    logic [15:0]   shreg_q, shreg_d;
    logic          miso_smp_q, miso_smp_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic          busy_q, busy_d;
    logic          ss_n_q, ss_n_d;
    logic          done_q, done_d;

    logic          wrt;
    logic [15:0]   cmd;

    always_comb begin
        div_d      = div_q;
        shreg_d    = shreg_q;
        miso_smp_d = miso_smp_q;
        bit_cnt_d  = bit_cnt_q;
        busy_d     = busy_q;
        ss_n_d     = ss_n_q;
        done_d     = 1'b0;

        if (!busy_q) begin
            if (wrt) begin
                shreg_d   = cmd;
                busy_d    = 1'b1;
                ss_n_d    = 1'b0;
                div_d     = DIV_PRESET;
                bit_cnt_d = 5'd0;
            end
        end else begin
            div_d = div_q + 1'b1;

            if (div_q == DIV_SMPL) begin
                miso_smp_d = bus.MISO;
                bit_cnt_d  = bit_cnt_q + 5'd1;
            end

            // The first all-ones after the preset precedes any sample, so
            // it only lets SCLK fall; MOSI keeps the command MSB there.
            if (div_q == DIV_ONES && bit_cnt_q != 5'd0) begin
                shreg_d = {shreg_q[14:0], miso_smp_q};
                if (bit_cnt_q == 5'd16) begin
                    // Last shift: park SCLK high and end the frame.
                    busy_d = 1'b0;
                    ss_n_d = 1'b1;
                    done_d = 1'b1;
                    div_d  = DIV_ONES;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= DIV_ONES;
            shreg_q    <= 16'h0000;
            miso_smp_q <= 1'b0;
            bit_cnt_q  <= 5'd0;
            busy_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            div_q      <= div_d;
            shreg_q    <= shreg_d;
            miso_smp_q <= miso_smp_d;
            bit_cnt_q  <= bit_cnt_d;
            busy_q     <= busy_d;
            ss_n_q     <= ss_n_d;
            done_q     <= done_d;
        end
    end

    assign bus.SS_n = ss_n_q;
    assign bus.SCLK = div_q[DW-1];
    assign bus.MOSI = shreg_q[15];

    // ------------------------------------------------------------------
    // Interrupt synchroniser
    // ------------------------------------------------------------------
    logic int_ff1_q, int_ff2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ff1_q <= 1'b0;
            int_ff2_q <= 1'b0;
        end else begin
            int_ff1_q <= bus.INT;
            int_ff2_q <= int_ff1_q;
        end
    end

    // ------------------------------------------------------------------
    // Transaction sequencer
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        PWRUP,
        INIT1,
        INIT2,
        INIT3,
        WAIT_INT,
        RD_L,
        RD_H
    } state_t;

    state_t                 state_q, state_d;
    logic [PWRUP_BITS-1:0]  timer_q, timer_d;
    logic [7:0]             yaw_l_q, yaw_l_d;
    logic [15:0]            yaw_q, yaw_d;
    logic                   vld_q, vld_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        yaw_l_d = yaw_l_q;
        yaw_d   = yaw_q;
        vld_d   = 1'b0;
        wrt     = 1'b0;
        cmd     = 16'h0000;

        case (state_q)
            PWRUP: begin
                timer_d = timer_q + 1'b1;
                if (&timer_q) begin
                    wrt     = 1'b1;
                    cmd     = CMD_INT_CFG;
                    state_d = INIT1;
                end
            end
            INIT1: begin
                if (done_q) begin
                    wrt     = 1'b1;
                    cmd     = CMD_ODR;
                    state_d = INIT2;
                end
            end
            INIT2: begin
                if (done_q) begin
                    wrt     = 1'b1;
                    cmd     = CMD_ROUND;
                    state_d = INIT3;
                end
            end
            INIT3: begin
                if (done_q) begin
                    state_d = WAIT_INT;
                end
            end
            WAIT_INT: begin
                if (int_ff2_q && !busy_q) begin
                    wrt     = 1'b1;
                    cmd     = CMD_RD_L;
                    state_d = RD_L;
                end
            end
            RD_L: begin
                if (done_q) begin
                    yaw_l_d = shreg_q[7:0];
                    wrt     = 1'b1;
                    cmd     = CMD_RD_H;
                    state_d = RD_H;
                end
            end
            RD_H: begin
                if (done_q) begin
                    // Both bytes land together, so yaw_rt is never torn.
                    yaw_d = {shreg_q[7:0], yaw_l_q};
                    vld_d = 1'b1;
                    // A still-pending interrupt chains straight into the
                    // next pair, keeping the inter-frame gap at one clock.
                    if (int_ff2_q) begin
                        wrt     = 1'b1;
                        cmd     = CMD_RD_L;
                        state_d = RD_L;
                    end else begin
                        state_d = WAIT_INT;
                    end
                end
            end
            default: begin
                state_d = PWRUP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PWRUP;
            timer_q <= '0;
            yaw_l_q <= 8'h00;
            yaw_q   <= 16'h0000;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            yaw_l_q <= yaw_l_d;
            yaw_q   <= yaw_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.vld    = vld_q;
    assign bus.yaw_rt = yaw_q;

endmodule

// File: tb/tb_inert_intf.sv
// tb/tb_inert_intf.sv - directed vector bench for inert_intf with a mode-3 gyro model
module tb_inert_intf;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inert_intf_if bus();

    inert_intf #(
        .PWRUP_BITS    (4),
        .SCLK_DIV_BITS (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errs   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Gyro model: captures MOSI on SCLK rise, drives MISO on SCLK fall.
    logic [15:0] rx;
    logic [7:0]  cmd_hi;
    logic [7:0]  sel;
    logic [7:0]  resp_l, resp_h;
    int          rises, falls;

    logic [15:0] frm_q[$];
    int          rise_q[$];
    int          gap_q[$];
    int          lat_q[$];
    int          vld_cnt;
    logic [15:0] yaw_mid;

    always @(negedge bus.SS_n) begin
        rx     = 16'h0000;
        cmd_hi = 8'h00;
        rises  = 0;
        falls  = 0;
    end

    always @(posedge bus.SCLK) begin
        if (!bus.SS_n) begin
            rx = {rx[14:0], bus.MOSI};
            rises++;
            if (rises == 8) cmd_hi = rx[7:0];
        end
    end

    always @(negedge bus.SCLK) begin
        if (!bus.SS_n) begin
            if (falls < 8) begin
                bus.MISO = 1'b0;
            end else begin
                sel = (cmd_hi == 8'hA6) ? resp_l : (cmd_hi == 8'hA7) ? resp_h : 8'h00;
                bus.MISO = sel[15 - falls];
            end
            falls++;
        end
    end

    always @(posedge bus.SS_n) begin
        if (rst_n) begin
            frm_q.push_back(rx);
            rise_q.push_back(rises);
            if (rx[15:8] == 8'hA6) yaw_mid = bus.yaw_rt;
        end
    end

    // Clocked monitor: SS_n-high run lengths and vld distance from frame end.
    int   hi_cnt;
    int   since;
    logic ss_prev;

    always @(negedge clk) begin
        if (!rst_n) begin
            hi_cnt  = 0;
            since   = 0;
            ss_prev = 1'b1;
        end else begin
            if (bus.SS_n) begin
                hi_cnt++;
            end else if (hi_cnt != 0) begin
                gap_q.push_back(hi_cnt);
                hi_cnt = 0;
            end
            if (bus.SS_n && !ss_prev) since = 0;
            else since++;
            if (bus.vld) begin
                vld_cnt++;
                lat_q.push_back(since);
            end
            ss_prev = bus.SS_n;
        end
    end

    task automatic clear_logs();
        frm_q.delete();
        rise_q.delete();
        gap_q.delete();
        lat_q.delete();
        vld_cnt = 0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frm_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("frame_wait_done", frm_q.size() >= n, 1);
    endtask

    task automatic wait_vld(input int n, input int budget);
        int k = 0;
        while (vld_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("vld_wait_done", vld_cnt >= n, 1);
    endtask

    typedef struct {
        logic [7:0]  l;
        logic [7:0]  h;
        logic [15:0] yaw;
    } vec_t;

    vec_t        vecs[4];
    logic [15:0] init_cmd[3];
    logic [15:0] prev_yaw;
    int          lat;
    int          k;

    initial begin
        vecs[0] = '{l: 8'h34, h: 8'h12, yaw: 16'h1234};
        vecs[1] = '{l: 8'h00, h: 8'hFF, yaw: 16'hFF00};
        vecs[2] = '{l: 8'hFF, h: 8'h7F, yaw: 16'h7FFF};
        vecs[3] = '{l: 8'h01, h: 8'h80, yaw: 16'h8001};
        init_cmd[0] = 16'h0D02;
        init_cmd[1] = 16'h1160;
        init_cmd[2] = 16'h1440;

        bus.INT  = 1'b0;
        bus.MISO = 1'b0;
        resp_l   = 8'h00;
        resp_h   = 8'h00;
        vld_cnt  = 0;
        yaw_mid  = 16'h0000;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ss_n", bus.SS_n, 1);
        check("rst_sclk", bus.SCLK, 1);
        check("rst_mosi", bus.MOSI, 0);
        check("rst_vld", bus.vld, 0);
        check("rst_yaw", bus.yaw_rt, 16'h0000);

        @(posedge clk);
        #1 rst_n = 1'b1;

        // Power-up wait then three configuration frames.
        wait_frames(3, 3000);
        repeat (50) @(negedge clk);
        check("init_frame_count", frm_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("init_cmd%0d", i), frm_q[i], init_cmd[i]);
            check($sformatf("init_rises%0d", i), rise_q[i], 16);
        end
        check("pwrup_ss_high", gap_q[0], 16);
        check("init_gap1", gap_q[1], 1);
        check("init_gap2", gap_q[2], 1);
        check("init_no_vld", vld_cnt, 0);

        // One interrupt per vector: low/high reads and the assembled rate.
        prev_yaw = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            clear_logs();
            resp_l = vecs[i].l;
            resp_h = vecs[i].h;
            @(negedge clk);
            bus.INT = 1'b1;
            lat = 0;
            while (bus.SS_n && lat < 10) begin
                @(negedge clk);
                lat++;
                if (lat == 2) bus.INT = 1'b0;
            end
            bus.INT = 1'b0;
            check($sformatf("v%0d_int_latency", i), lat, 3);
            wait_vld(1, 3000);
            repeat (20) @(negedge clk);
            check($sformatf("v%0d_frames", i), frm_q.size(), 2);
            check($sformatf("v%0d_cmd_l", i), frm_q[0], 16'hA600);
            check($sformatf("v%0d_cmd_h", i), frm_q[1], 16'hA700);
            check($sformatf("v%0d_yaw", i), bus.yaw_rt, vecs[i].yaw);
            check($sformatf("v%0d_yaw_between", i), yaw_mid, prev_yaw);
            check($sformatf("v%0d_vld_count", i), vld_cnt, 1);
            check($sformatf("v%0d_vld_latency", i), lat_q[0], 1);
            check($sformatf("v%0d_pair_gap", i), gap_q[1], 1);
            prev_yaw = vecs[i].yaw;
        end

        // INT toggled during the high-byte read must not add a frame.
        clear_logs();
        resp_l = 8'h56;
        resp_h = 8'h78;
        @(negedge clk);
        bus.INT = 1'b1;
        repeat (2) @(negedge clk);
        bus.INT = 1'b0;
        k = 0;
        while (!(frm_q.size() == 1 && !bus.SS_n && rises >= 4) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("tog_reached_rd_h", k < 3000, 1);
        bus.INT = 1'b1;
        repeat (3) @(negedge clk);
        bus.INT = 1'b0;
        wait_vld(1, 3000);
        repeat (1200) @(negedge clk);
        check("tog_frames", frm_q.size(), 2);
        check("tog_vld_count", vld_cnt, 1);
        check("tog_yaw", bus.yaw_rt, 16'h7856);

        // INT held high: back-to-back pairs, then reset mid low-byte read.
        clear_logs();
        resp_l = 8'h9A;
        resp_h = 8'hBC;
        @(negedge clk);
        bus.INT = 1'b1;
        wait_vld(2, 4000);
        k = 0;
        while (!(frm_q.size() >= 4 && !bus.SS_n && rises == 8) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("held_reached_8th_sclk", k < 2000, 1);
        check("held_cmd0", frm_q[0], 16'hA600);
        check("held_cmd1", frm_q[1], 16'hA700);
        check("held_cmd2", frm_q[2], 16'hA600);
        check("held_cmd3", frm_q[3], 16'hA700);
        for (int i = 1; i < 5; i++) begin
            check($sformatf("held_gap%0d", i), gap_q[i], 1);
        end
        check("held_vld_count", vld_cnt, 2);
        check("held_vld_lat0", lat_q[0], 1);
        check("held_vld_lat1", lat_q[1], 1);
        check("held_yaw", bus.yaw_rt, 16'hBC9A);

        #2 rst_n = 1'b0;
        #1;
        check("abort_ss_n", bus.SS_n, 1);
        check("abort_sclk", bus.SCLK, 1);
        check("abort_vld", bus.vld, 0);
        check("abort_yaw", bus.yaw_rt, 16'h0000);
        repeat (3) @(posedge clk);
        clear_logs();
        #1 rst_n = 1'b1;

        // INT still high: init must fully repeat before the first read.
        wait_frames(4, 4000);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reinit_cmd%0d", i), frm_q[i], init_cmd[i]);
        end
        check("reinit_first_read", frm_q[3], 16'hA600);
        check("reinit_pwrup_ss_high", gap_q[0], 16);
        check("reinit_no_vld", vld_cnt, 0);
        bus.INT = 1'b0;
        wait_vld(1, 2000);
        repeat (10) @(negedge clk);
        check("reinit_yaw", bus.yaw_rt, 16'hBC9A);
        check("reinit_vld_count", vld_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule

// File: doc/inert_intf.md
Name: inert_intf

Overview:
- SPI-side producer of the gyro yaw-rate stream consumed by the heading integrator.
- After power-up it configures the gyro over SPI, then waits for each data-ready interrupt (INT).
- On each interrupt it reads the 16-bit yaw rate as two 8-bit register reads and presents it as yaw_rt with a one-cycle vld strobe.
- Contains its own 16-bit SPI master (mode 3) and the transaction sequencer.

Parameters:
- PWRUP_BITS, 16, width of power-up wait timer; wait = 2^PWRUP_BITS clocks (bench sets 4).
- SCLK_DIV_BITS, 5, SCLK period = 2^SCLK_DIV_BITS clocks.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- INT  in  1  gyro data-ready interrupt, asynchronous, active high
- MISO  in  1  SPI data from gyro
- SS_n  out  1  SPI select, active low
- SCLK  out  1  SPI clock, idles high
- MOSI  out  1  SPI data to gyro, MSB first
- vld  out  1  one-cycle pulse: yaw_rt updated
- yaw_rt  out  16  signed yaw rate {yawH,yawL}

Behaviour:
- Reset values: SS_n=1, SCLK=1, MOSI=0, vld=0, yaw_rt=0, state=PWRUP, timer=0.
- Reset asserted mid-transaction aborts it immediately (SS_n=1 asynchronously). Init restarts from PWRUP.

SPI master:
- 16-bit frames. A wrt pulse loads cmd[15:0] into the shift register, drops SS_n on the next clock and presets the divider to 5'b10111.
- SCLK = div[4].
- MISO is sampled into a 1-bit flop when div==5'b01111 (one clock before SCLK rises).
- The shift register shifts left, inserting the sampled bit, when div==5'b11111 (SCLK fall). MOSI = shreg[15].
- After 16 shifts the divider is held at 5'b11111 (SCLK high), SS_n returns high, and done pulses for one clock.
- rd_data = shreg[15:0] after done.
- wrt is ignored while busy.

Sequencer states: PWRUP, INIT1, INIT2, INIT3, WAIT_INT, RD_L, RD_H.
- PWRUP: timer counts every clock. On all-ones, issue 0x0D02 (INT on data ready) and go to INIT1.
- INIT1 on done: issue 0x1160 (gyro ODR 416 Hz) and go to INIT2.
- INIT2 on done: issue 0x1440 (rounding enable) and go to INIT3.
- INIT3 on done: go to WAIT_INT.
- WAIT_INT: INT is double-flopped (INT_ff2). When INT_ff2=1 and SPI is idle, issue 0xA600 (read yawL) and go to RD_L.
- RD_L on done: capture rd_data[7:0] as yawL, issue 0xA700 (read yawH), go to RD_H.
- RD_H on done: yaw_rt <= {rd_data[7:0], yawL}. vld=1 on the following clock only. Return to WAIT_INT.
- yaw_rt holds its value between reads. Only the high-byte read updates it, so no torn value is ever visible.
- INT re-asserted or held during RD_L/RD_H is ignored. If INT_ff2 is still high on return to WAIT_INT, a new read starts immediately.
- INT pulse latency: INT rise to SS_n fall = 3 clocks (2 synchroniser flops + 1 issue cycle).
- Back-to-back frames: at least 1 clock with SS_n high between frames.
- vld never asserts during init.

Test Plan:
- Reset then idle with PWRUP_BITS=4, INT=0 -> SS_n high for 16 clocks, then three frames on MOSI: 0x0D02, 0x1160, 0x1440, each framed by SS_n low with exactly 16 SCLK rising edges. No vld.
- After init, pulse INT; SPI model returns 0x34 on the 0xA600 read and 0x12 on the 0xA700 read -> MOSI shows 0xA600 then 0xA700, yaw_rt=16'h1234, vld high exactly 1 clock after the second done.
- Negative rate: model returns L=0x00, H=0xFF -> yaw_rt=16'hFF00 (−256); yaw_rt is unchanged between the L and H reads.
- INT held high continuously -> consecutive read pairs with no gap beyond the 1-clock SS_n-high minimum; one vld per pair.
- INT toggled during RD_H -> no extra frame inserted; exactly one vld for that pair.
- rst_n dropped at the 8th SCLK of the 0xA600 frame -> SS_n=1, SCLK=1, vld=0 immediately. After release, the full PWRUP plus three init frames repeat before any read.
